// File: rtl/types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | types_pkg                                                            |
// | Shared widths and pipeline record types for the ALU issue path.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package types_pkg;

    localparam int RS_DEPTH = 8;
    localparam int PREG_W   = 7;
    localparam int AGE_W    = 3;
    localparam int ROB_W    = 5;
    localparam int OPC_W    = 7;
    localparam int IMM_W    = 32;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic              pr1_ready;
        logic [PREG_W-1:0] pr2;
        logic              pr2_ready;
        logic [IMM_W-1:0]  imm;
        logic [ROB_W-1:0]  rob_index;
    } dispatch_pipeline_data;

    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic              pr1_ready;
        logic [PREG_W-1:0] pr2;
        logic              pr2_ready;
        logic [IMM_W-1:0]  imm;
        logic [ROB_W-1:0]  rob_index;
        logic [1:0]        fu;
        logic [AGE_W-1:0]  age;
    } alu_rs_data;

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs_age_select                                                        |
// | Picks the eligible entry with the largest age (the oldest).          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rs_age_select
    import types_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]            eligible,
    input  logic [N-1:0][AGE_W-1:0] ages,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    any_grant
);

    logic [AGE_W-1:0] w_best;

    // Ages of valid entries are unique, so strict > never needs a tie-break.
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        w_best    = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && (!any_grant || ages[i] > w_best)) begin
                grant_idx = IDX_W'(i);
                w_best    = ages[i];
                any_grant = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_reservation_station                                              |
// | Age-ordered ALU reservation station with CDB wakeup and bypass.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_reservation_station
    import types_pkg::*;
#(
    parameter int RS_DEPTH  = 8,
    parameter int CDB_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                disp_valid,
    input  dispatch_pipeline_data               disp_data,
    output logic                                disp_ready,
    input  logic [CDB_PORTS-1:0]                cdb_valid,
    input  logic [CDB_PORTS-1:0][PREG_W-1:0]    cdb_prd,
    output logic                                issue_valid,
    output alu_rs_data                          issue_data,
    input  logic                                issue_ready,
    output logic [3:0]                          rs_count
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    alu_rs_data                     r_entries [RS_DEPTH];
    logic [3:0]                     r_count;

    logic [RS_DEPTH-1:0]            w_eligible;
    logic [RS_DEPTH-1:0][AGE_W-1:0] w_ages;
    logic [RS_DEPTH-1:0]            w_wake1;
    logic [RS_DEPTH-1:0]            w_wake2;
    logic [IDX_W-1:0]               w_grant_idx;
    logic [IDX_W-1:0]               w_free_idx;
    logic                           w_any_grant;
    logic                           w_disp_fire;
    logic                           w_issue_fire;
    alu_rs_data                     w_new_entry;

    function automatic logic cdb_hit(
        input logic [PREG_W-1:0]                 tag,
        input logic [CDB_PORTS-1:0]              vld,
        input logic [CDB_PORTS-1:0][PREG_W-1:0]  prd
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (vld[p] && prd[p] == tag) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        w_eligible = '0;
        w_ages     = '0;
        w_wake1    = '0;
        w_wake2    = '0;
        w_free_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_eligible[i] = r_entries[i].valid && r_entries[i].pr1_ready && r_entries[i].pr2_ready;
            w_ages[i]     = r_entries[i].age;
            w_wake1[i]    = r_entries[i].valid && cdb_hit(r_entries[i].pr1, cdb_valid, cdb_prd);
            w_wake2[i]    = r_entries[i].valid && cdb_hit(r_entries[i].pr2, cdb_valid, cdb_prd);
        end
        // Descending scan leaves the lowest free index as the winner.
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_entries[i].valid) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_new_entry           = '0;
        w_new_entry.valid     = 1'b1;
        w_new_entry.opcode    = disp_data.opcode;
        w_new_entry.prd       = disp_data.prd;
        w_new_entry.pr1       = disp_data.pr1;
        w_new_entry.pr2       = disp_data.pr2;
        w_new_entry.imm       = disp_data.imm;
        w_new_entry.rob_index = disp_data.rob_index;
        w_new_entry.fu        = 2'b00;
        w_new_entry.age       = '0;
        w_new_entry.pr1_ready = disp_data.pr1_ready || (disp_data.pr1 == '0)
                                || cdb_hit(disp_data.pr1, cdb_valid, cdb_prd);
        w_new_entry.pr2_ready = disp_data.pr2_ready || (disp_data.pr2 == '0)
                                || cdb_hit(disp_data.pr2, cdb_valid, cdb_prd);
    end

    rs_age_select #(
        .N     (RS_DEPTH),
        .IDX_W (IDX_W)
    ) u_age_select (
        .eligible  (w_eligible),
        .ages      (w_ages),
        .grant_idx (w_grant_idx),
        .any_grant (w_any_grant)
    );

    // Readiness comes from the count alone so an issue cannot free a slot the same cycle.
    assign disp_ready   = (r_count < 4'(RS_DEPTH));
    assign issue_valid  = w_any_grant && !flush;
    assign issue_data   = r_entries[w_grant_idx];
    assign rs_count     = r_count;
    assign w_disp_fire  = disp_valid && disp_ready && !flush;
    assign w_issue_fire = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_wake1[i]) begin
                    r_entries[i].pr1_ready <= 1'b1;
                end
                if (w_wake2[i]) begin
                    r_entries[i].pr2_ready <= 1'b1;
                end
                if (w_disp_fire) begin
                    if (IDX_W'(i) == w_free_idx) begin
                        r_entries[i] <= w_new_entry;
                    end else if (r_entries[i].valid) begin
                        r_entries[i].age <= r_entries[i].age + 1'b1;
                    end
                end
                if (w_issue_fire && IDX_W'(i) == w_grant_idx) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
            r_count <= r_count + {3'b000, w_disp_fire} - {3'b000, w_issue_fire};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_reservation_station                                           |
// | Self-checking bench: vector table plus issue-order scoreboard.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_reservation_station;
    import types_pkg::*;

    localparam int CDB_PORTS = 2;

    logic                             clk = 1'b0;
    logic                             reset;
    logic                             flush;
    logic                             disp_valid;
    dispatch_pipeline_data            disp_data;
    logic                             disp_ready;
    logic [CDB_PORTS-1:0]             cdb_valid;
    logic [CDB_PORTS-1:0][PREG_W-1:0] cdb_prd;
    logic                             issue_valid;
    alu_rs_data                       issue_data;
    logic                             issue_ready;
    logic [3:0]                       rs_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [ROB_W-1:0] sb_q [$];

    typedef struct packed {
        logic [PREG_W-1:0] pr1;
        logic              r1;
        logic [PREG_W-1:0] pr2;
        logic              r2;
        logic [ROB_W-1:0]  rob;
        logic [3:0]        exp_count;
        logic              exp_ready;
    } vec_t;

    vec_t vecs [8];

    alu_reservation_station #(
        .RS_DEPTH  (8),
        .CDB_PORTS (CDB_PORTS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_data   (disp_data),
        .disp_ready  (disp_ready),
        .cdb_valid   (cdb_valid),
        .cdb_prd     (cdb_prd),
        .issue_valid (issue_valid),
        .issue_data  (issue_data),
        .issue_ready (issue_ready),
        .rs_count    (rs_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dispatch_pipeline_data mk(
        input logic [PREG_W-1:0] pr1, input logic r1,
        input logic [PREG_W-1:0] pr2, input logic r2,
        input logic [ROB_W-1:0]  rob
    );
        dispatch_pipeline_data d;
        d.opcode    = 7'h33;
        d.prd       = {2'b01, rob};
        d.pr1       = pr1;
        d.pr1_ready = r1;
        d.pr2       = pr2;
        d.pr2_ready = r2;
        d.imm       = {27'd0, rob} * 32'd3 + 32'h100;
        d.rob_index = rob;
        return d;
    endfunction

    task automatic dispatch(
        input logic [PREG_W-1:0] pr1, input logic r1,
        input logic [PREG_W-1:0] pr2, input logic r2,
        input logic [ROB_W-1:0]  rob
    );
        disp_data  = mk(pr1, r1, pr2, r2, rob);
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic issue_one(input string nm);
        int waited;
        waited      = 0;
        issue_ready = 1'b0;
        while (!issue_valid && waited < 20) begin
            tick();
            waited++;
        end
        if (!issue_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: issue_valid never rose within 20 cycles", nm);
        end else if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: unexpected issue of rob %0d, scoreboard empty", nm, issue_data.rob_index);
        end else begin
            check(nm, 128'(issue_data.rob_index), 128'(sb_q.pop_front()));
            issue_ready = 1'b1;
            tick();
            issue_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_rs_data exp_e;

        reset       = 1'b1;
        flush       = 1'b0;
        disp_valid  = 1'b0;
        disp_data   = '0;
        cdb_valid   = '0;
        cdb_prd     = '0;
        issue_ready = 1'b0;

        // Reset must win over a concurrent dispatch.
        tick();
        disp_data  = mk(7'd0, 1'b1, 7'd0, 1'b1, 5'd31);
        disp_valid = 1'b1;
        tick();
        disp_valid = 1'b0;
        reset      = 1'b0;
        #1;
        check("reset_count", 128'(rs_count), 128'(0));
        check("reset_disp_ready", 128'(disp_ready), 128'(1));
        check("reset_issue_valid", 128'(issue_valid), 128'(0));

        // Fill to capacity, including tag-0 sources offered as not ready.
        vecs[0] = '{pr1: 7'd0,  r1: 1'b0, pr2: 7'd0,  r2: 1'b0, rob: 5'd0, exp_count: 4'd1, exp_ready: 1'b1};
        vecs[1] = '{pr1: 7'd5,  r1: 1'b1, pr2: 7'd6,  r2: 1'b1, rob: 5'd1, exp_count: 4'd2, exp_ready: 1'b1};
        vecs[2] = '{pr1: 7'd0,  r1: 1'b0, pr2: 7'd9,  r2: 1'b1, rob: 5'd2, exp_count: 4'd3, exp_ready: 1'b1};
        vecs[3] = '{pr1: 7'd11, r1: 1'b1, pr2: 7'd0,  r2: 1'b0, rob: 5'd3, exp_count: 4'd4, exp_ready: 1'b1};
        vecs[4] = '{pr1: 7'd40, r1: 1'b1, pr2: 7'd41, r2: 1'b1, rob: 5'd4, exp_count: 4'd5, exp_ready: 1'b1};
        vecs[5] = '{pr1: 7'd42, r1: 1'b1, pr2: 7'd43, r2: 1'b1, rob: 5'd5, exp_count: 4'd6, exp_ready: 1'b1};
        vecs[6] = '{pr1: 7'd44, r1: 1'b1, pr2: 7'd0,  r2: 1'b1, rob: 5'd6, exp_count: 4'd7, exp_ready: 1'b1};
        vecs[7] = '{pr1: 7'd45, r1: 1'b1, pr2: 7'd46, r2: 1'b1, rob: 5'd7, exp_count: 4'd8, exp_ready: 1'b0};

        for (int i = 0; i < 8; i++) begin
            dispatch(vecs[i].pr1, vecs[i].r1, vecs[i].pr2, vecs[i].r2, vecs[i].rob);
            sb_q.push_back(vecs[i].rob);
            check($sformatf("fill_count[%0d]", i), 128'(rs_count), 128'(vecs[i].exp_count));
            check($sformatf("fill_ready[%0d]", i), 128'(disp_ready), 128'(vecs[i].exp_ready));
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_count[%0d]", k), 128'(rs_count), 128'(8 - k));
            check($sformatf("drain_valid[%0d]", k), 128'(issue_valid), 128'(1));
            check($sformatf("drain_age[%0d]", k), 128'(issue_data.age), 128'(7 - k));
            issue_one($sformatf("drain_order[%0d]", k));
        end
        check("drain_empty_count", 128'(rs_count), 128'(0));
        check("drain_empty_valid", 128'(issue_valid), 128'(0));

        // Older entry waits on tag 10; younger ready entry goes first.
        dispatch(7'd10, 1'b0, 7'd0, 1'b1, 5'd1);
        dispatch(7'd20, 1'b1, 7'd21, 1'b1, 5'd2);
        sb_q.push_back(5'd2);
        issue_one("younger_ready_first");
        check("older_still_waiting", 128'(issue_valid), 128'(0));
        cdb_valid  = 2'b01;
        cdb_prd[0] = 7'd10;
        #1;
        check("wakeup_not_same_cycle", 128'(issue_valid), 128'(0));
        tick();
        cdb_valid = '0;
        check("wakeup_next_cycle", 128'(issue_valid), 128'(1));
        sb_q.push_back(5'd1);
        issue_one("woken_entry");

        // Same-cycle broadcast on port 1 bypasses into the new entry.
        cdb_valid  = 2'b10;
        cdb_prd[1] = 7'd12;
        dispatch(7'd0, 1'b0, 7'd12, 1'b0, 5'd3);
        cdb_valid = '0;
        check("bypass_ready", 128'(issue_valid), 128'(1));
        sb_q.push_back(5'd3);
        issue_one("bypass_issue");

        // Full station: issue and dispatch together, dispatch refused.
        for (int j = 0; j < 8; j++) begin
            dispatch(7'd50, 1'b1, 7'd51, 1'b1, 5'(8 + j));
            sb_q.push_back(5'(8 + j));
        end
        check("full_disp_ready", 128'(disp_ready), 128'(0));
        disp_data   = mk(7'd0, 1'b1, 7'd0, 1'b1, 5'd16);
        disp_valid  = 1'b1;
        issue_ready = 1'b1;
        #1;
        check("full_swap_valid", 128'(issue_valid), 128'(1));
        check("full_swap_rob", 128'(issue_data.rob_index), 128'(sb_q.pop_front()));
        tick();
        disp_valid  = 1'b0;
        issue_ready = 1'b0;
        check("full_swap_count", 128'(rs_count), 128'(7));
        check("full_swap_ready", 128'(disp_ready), 128'(1));
        dispatch(7'd0, 1'b1, 7'd0, 1'b1, 5'd16);
        sb_q.push_back(5'd16);
        check("refill_count", 128'(rs_count), 128'(8));
        for (int k = 0; k < 8; k++) begin
            issue_one($sformatf("full_drain[%0d]", k));
        end
        check("full_drain_count", 128'(rs_count), 128'(0));

        // Flush with an eligible entry and a dispatch pending.
        for (int j = 0; j < 5; j++) begin
            dispatch(7'd60, 1'b1, 7'd61, 1'b1, 5'(17 + j));
        end
        check("preflush_count", 128'(rs_count), 128'(5));
        disp_data  = mk(7'd0, 1'b1, 7'd0, 1'b1, 5'd22);
        disp_valid = 1'b1;
        flush      = 1'b1;
        #1;
        check("flush_suppresses_issue", 128'(issue_valid), 128'(0));
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        check("flush_count", 128'(rs_count), 128'(0));
        check("flush_issue_valid", 128'(issue_valid), 128'(0));
        check("flush_disp_ready", 128'(disp_ready), 128'(1));
        tick();
        check("flush_no_leftover", 128'(issue_valid), 128'(0));

        // Held issue: full record stays stable under backpressure.
        dispatch(7'd7, 1'b1, 7'd8, 1'b1, 5'd23);
        exp_e           = '0;
        exp_e.valid     = 1'b1;
        exp_e.opcode    = 7'h33;
        exp_e.prd       = 7'h37;
        exp_e.pr1       = 7'd7;
        exp_e.pr1_ready = 1'b1;
        exp_e.pr2       = 7'd8;
        exp_e.pr2_ready = 1'b1;
        exp_e.imm       = 32'd23 * 32'd3 + 32'h100;
        exp_e.rob_index = 5'd23;
        exp_e.fu        = 2'b00;
        exp_e.age       = 3'd0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall_valid[%0d]", c), 128'(issue_valid), 128'(1));
            check($sformatf("stall_data[%0d]", c), 128'(issue_data), 128'(exp_e));
            tick();
        end
        sb_q.push_back(5'd23);
        issue_one("stall_release");
        check("final_count", 128'(rs_count), 128'(0));
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 8, number of entries (fixed 8; the 3-bit age field bounds it).
REQ-002 SHALL have parameter CDB_PORTS, default 2, number of wakeup broadcast ports.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  mispredict flush; discards all entries.
REQ-006 SHALL have port disp_valid  input  1  dispatch offers one instruction.
REQ-007 SHALL have port disp_data  input  dispatch_pipeline_data  opcode, prd, pr1/pr2 with ready bits, imm, rob_index.
REQ-008 SHALL have port disp_ready  output  1  an entry is free.
REQ-009 SHALL have port cdb_valid  input  CDB_PORTS  per-port broadcast valid.
REQ-010 SHALL have port cdb_prd  input  CDB_PORTS x 7  per-port broadcast physical register tag.
REQ-011 SHALL have port issue_valid  output  1  issue_data is a ready instruction.
REQ-012 SHALL have port issue_data  output  alu_rs_data  selected entry (valid=1, age as stored).
REQ-013 SHALL have port issue_ready  input  1  ALU accepts this cycle.
REQ-014 SHALL have port rs_count  output  4  number of valid entries, 0..8.

Function
REQ-015 Dispatch handshake SHALL complete in a cycle when disp_valid && disp_ready && !flush; the instruction is written into the lowest-index free entry with valid=1, age=0, fu=2'b00.
REQ-016 disp_ready SHALL equal (rs_count < 8); a same-cycle issue SHALL NOT free a slot for that cycle's dispatch.
REQ-017 On each completed dispatch, every other valid entry's age SHALL increment by 1; ages of valid entries therefore remain unique, and the largest age is the oldest.
REQ-018 Wakeup: for each valid cdb port, any valid entry with pr1 (pr2) equal to cdb_prd SHALL set pr1_ready (pr2_ready) on the next edge.
REQ-019 Dispatch bypass: a dispatching instruction whose pr1/pr2 matches a valid cdb_prd in the same cycle SHALL be stored with that ready bit set.
REQ-020 Source tag 0 SHALL be stored as ready regardless of the incoming ready bit.
REQ-021 An entry SHALL be issue-eligible when valid && pr1_ready && pr2_ready, evaluated from registered state; wakeup takes effect for selection one cycle after broadcast.
REQ-022 issue_valid SHALL be asserted combinationally when any entry is eligible and flush is low; issue_data SHALL be the eligible entry with the largest age.
REQ-023 issue_data SHALL hold stable while issue_valid && !issue_ready; when a newly eligible older entry appears, selection MAY change.
REQ-024 On issue_valid && issue_ready, the selected entry SHALL be invalidated on the next edge; other entries' ages are unchanged.
REQ-025 Simultaneous dispatch and issue SHALL both take effect; rs_count then holds its value.
REQ-026 rs_count SHALL be updated as +1 per dispatch and -1 per issue, and SHALL never exceed 8 or go below 0.
REQ-027 flush SHALL clear all valid bits on the next edge, suppress issue_valid and the dispatch handshake that cycle, and set rs_count to 0.

Reset
REQ-028 On reset, all entries SHALL be invalid, ages SHALL be 0, rs_count SHALL be 0, issue_valid SHALL be 0, and disp_ready SHALL be 1.
REQ-029 Reset SHALL take priority over flush, dispatch, wakeup and issue in the same cycle.

Structure
REQ-030 dispatch_pipeline_data and alu_rs_data SHALL come from types_pkg; RS_DEPTH and a localparam for the 7-bit physical tag width SHALL be added to types_pkg.
REQ-031 Oldest-eligible selection SHALL be a combinational sub-module rs_age_select (inputs: eligible vector and ages; outputs: grant index and any-grant).

Verification
REQ-032 Reset, then dispatch 8 entries all ready -> disp_ready=0 after the 8th; issue order is dispatch order; rs_count goes 8..0.
REQ-033 Dispatch A(pr1=10 not ready), then B ready -> B issues first; cdb_prd=10 in cycle t -> A issue_valid at t+1.
REQ-034 Dispatch with pr2=12 while cdb_prd[1]=12 is valid in the same cycle -> entry stored ready; issues next cycle.
REQ-035 Full RS, issue_ready=1 and disp_valid=1 in the same cycle -> issue completes, dispatch is refused; rs_count=7, then dispatch accepted.
REQ-036 5 entries, flush with disp_valid=1 and an eligible entry -> no issue and no dispatch; rs_count=0 next cycle.
REQ-037 issue_ready held 0 for 3 cycles with one eligible entry -> issue_data stable; accepted on release.
